// File: rtl/tlb_isr_sched_pkg.sv
// Shared types for the ISR DMA scheduler: request structs, FSM state, ID width helper.
package tlb_isr_sched_pkg;
  localparam int PADDR_W = 48;
  localparam int LEN_W   = 28;
  localparam int CTL_W   = 4;
  localparam int DEST_W  = 4;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} sched_state_t;

  typedef struct packed {
    logic [PADDR_W-1:0] paddr_host;
    logic [PADDR_W-1:0] paddr_card;
    logic [LEN_W-1:0]   len;
    logic [CTL_W-1:0]   ctl;
    logic [DEST_W-1:0]  dest;
  } isr_req_t;

  typedef struct packed {
    logic [PADDR_W-1:0] paddr;
    logic [LEN_W-1:0]   len;
    logic [CTL_W-1:0]   ctl;
    logic [DEST_W-1:0]  dest;
  } dma_req_t;

  // Requester ID width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tlb_isr_sched_if.sv
// Requester-side ISR DMA bundle (all ports packed together) and a single DMA leg.
interface dma_isr_if #(parameter int N_REQ = 4);
  import tlb_isr_sched_pkg::*;
  logic [N_REQ-1:0] valid;
  logic [N_REQ-1:0] ready;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] isr_return;
  isr_req_t [N_REQ-1:0] req;
  modport m (output valid, req, input ready, done, isr_return);
  modport s (input valid, req, output ready, done, isr_return);
endinterface

interface dma_if;
  import tlb_isr_sched_pkg::*;
  logic     valid;
  logic     ready;
  logic     done;
  dma_req_t req;
  modport m (output valid, req, input ready, done);
  modport s (input valid, req, output ready, done);
endinterface

// File: rtl/tlb_isr_sched_order_fifo.sv
// Issue-order FIFO of requester IDs; completions pop the oldest issued ID.
module isr_order_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
)(
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/tlb_isr_sched.sv
// Round-robin ISR DMA scheduler: captures one requester, forks it to host and card
// legs with independent handshakes, and routes completions back in issue order.
module tlb_isr_sched import tlb_isr_sched_pkg::*; #(
  parameter int  N_REQ           = 4,
  parameter bit  RDWR            = 1'b0,
  parameter int  MAX_OUTSTANDING = 8,
  localparam int ID_W            = id_width(N_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
)(
  input  logic             aclk,
  input  logic             aresetn,
  dma_isr_if.s             req_snk,
  dma_if.m                 req_src_host,
  dma_if.m                 req_src_card,
  output logic             busy,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_underflow
);
  sched_state_t     state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, grant, head_id;
  logic [N_REQ-1:0] ready_vec, done_q;
  logic             any_valid, capture, fifo_full, fifo_empty;
  logic             sel_done, pop;
  logic             host_vld, card_vld, host_sent, card_sent;
  logic             host_hs, card_hs, both_sent;
  isr_req_t         req_q;
  int               idx;

  // First valid requester at or after the RR pointer, wrapping.
  always_comb begin
    grant     = rr_ptr;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && req_snk.valid[idx]) begin
        any_valid = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

  assign capture   = (state == ST_IDLE) & any_valid & ~fifo_full;
  assign host_hs   = host_vld & req_src_host.ready;
  assign card_hs   = card_vld & req_src_card.ready;
  assign both_sent = (host_sent | host_hs) & (card_sent | card_hs);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_vec = '0;
    case (state)
      ST_IDLE: if (capture) begin
        state_nxt        = ST_ISSUE;
        ready_vec[grant] = 1'b1;
      end
      ST_ISSUE: if (both_sent) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_q     <= '0;
      rr_ptr    <= '0;
      host_vld  <= 1'b0;
      card_vld  <= 1'b0;
      host_sent <= 1'b0;
      card_sent <= 1'b0;
    end else begin
      if (capture) begin
        req_q  <= req_snk.req[grant];
        rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
      end
      host_vld <= capture | (host_vld & ~req_src_host.ready);
      card_vld <= capture | (card_vld & ~req_src_card.ready);
      if (state == ST_ISSUE && both_sent) begin
        host_sent <= 1'b0;
        card_sent <= 1'b0;
      end else begin
        if (host_hs) host_sent <= 1'b1;
        if (card_hs) card_sent <= 1'b1;
      end
    end
  end

  // Only the leg chosen by RDWR reports completion; the other leg's done is dropped.
  assign sel_done = RDWR ? req_src_host.done : req_src_card.done;
  assign pop      = sel_done & ~fifo_empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done_q        <= '0;
      err_underflow <= 1'b0;
    end else begin
      done_q <= '0;
      if (pop) done_q[head_id] <= 1'b1;
      if (sel_done && fifo_empty) err_underflow <= 1'b1;
    end
  end

  isr_order_fifo #(.W(ID_W), .DEPTH(MAX_OUTSTANDING)) u_order_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (capture),
    .pop     (pop),
    .din     (grant),
    .dout    (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (outstanding)
  );

  assign req_snk.ready      = ready_vec;
  assign req_snk.done       = done_q;
  assign req_snk.isr_return = '0;

  assign req_src_host.valid = host_vld;
  assign req_src_host.req   = '{paddr: req_q.paddr_host, len: req_q.len, ctl: req_q.ctl, dest: req_q.dest};
  assign req_src_card.valid = card_vld;
  assign req_src_card.req   = '{paddr: req_q.paddr_card, len: req_q.len, ctl: req_q.ctl, dest: req_q.dest};

  assign busy = (state == ST_ISSUE) | (outstanding != '0);
endmodule

// File: tb/tb_tlb_isr_sched.sv
// Bench for tlb_isr_sched: directed vector table, hand sequences for multi-cycle
// corners, and a randomized run against a transaction-level reference model.
module tb_tlb_isr_sched;
  import tlb_isr_sched_pkg::*;
  localparam int N = 4;
  localparam int MAX = 8;
  localparam int CW = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  dma_isr_if #(.N_REQ(N)) snk0();
  dma_isr_if #(.N_REQ(N)) snk1();
  dma_if host0();
  dma_if card0();
  dma_if host1();
  dma_if card1();
  logic busy0, busy1, err0, err1;
  logic [CW-1:0] out0, out1;

  tlb_isr_sched #(.N_REQ(N), .RDWR(1'b0), .MAX_OUTSTANDING(MAX)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .req_snk(snk0), .req_src_host(host0),
    .req_src_card(card0), .busy(busy0), .outstanding(out0), .err_underflow(err0));
  tlb_isr_sched #(.N_REQ(N), .RDWR(1'b1), .MAX_OUTSTANDING(MAX)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .req_snk(snk1), .req_src_host(host1),
    .req_src_card(card1), .busy(busy1), .outstanding(out1), .err_underflow(err1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference model state (dut0, RDWR = 0)
  int       m_q[$];
  int       m_rr;
  bit       m_issue, m_hp, m_cp, m_err;
  logic [3:0] m_done;
  isr_req_t m_req;

  task automatic do_reset();
    aresetn = 1'b0;
    snk0.valid = '0; snk0.req = '0; snk1.valid = '0; snk1.req = '0;
    host0.ready = 1'b0; host0.done = 1'b0; card0.ready = 1'b0; card0.done = 1'b0;
    host1.ready = 1'b0; host1.done = 1'b0; card1.ready = 1'b0; card1.done = 1'b0;
    m_q.delete(); m_rr = 0; m_issue = 0; m_hp = 0; m_cp = 0; m_err = 0; m_done = '0; m_req = '0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  function automatic isr_req_t mk_req(input logic [47:0] ph, input logic [47:0] pc, input logic [27:0] len);
    isr_req_t r;
    r = '0;
    r.paddr_host = ph; r.paddr_card = pc; r.len = len;
    return r;
  endfunction

  function automatic isr_req_t rnd_req();
    isr_req_t r;
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    r.paddr_host = a[47:0]; r.paddr_card = b[47:0];
    r.len = LEN_W'($urandom); r.ctl = CTL_W'($urandom); r.dest = DEST_W'($urandom);
    return r;
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int start);
    for (int k = 0; k < N; k++) if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic int bit_id(input logic [3:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  typedef struct {
    logic [3:0] v; logic hr, cr, cd, hd;
    logic [3:0] rdy; logic hv, cv; logic [3:0] out; logic bsy; logic [3:0] dn;
    logic [47:0] hp, cp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t row(input logic [3:0] v, input logic hr, input logic cr, input logic cd,
      input logic hd, input logic [3:0] rdy, input logic hv, input logic cv, input logic [3:0] out,
      input logic bsy, input logic [3:0] dn, input logic [47:0] hp, input logic [47:0] cp);
    vec_t r;
    r.v = v; r.hr = hr; r.cr = cr; r.cd = cd; r.hd = hd; r.rdy = rdy; r.hv = hv; r.cv = cv;
    r.out = out; r.bsy = bsy; r.dn = dn; r.hp = hp; r.cp = cp;
    return r;
  endfunction

  int grants[$];
  int last_cap, caps, g;
  logic [3:0] v, exp_rdy, nd;
  bit cap;

  initial begin
    // Single request, then leg skew; req0 = 0x1000/0x2000/64, req1 = 0x3000/0x4000/128
    tbl.push_back(row(4'h1, 0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(row(4'h0, 1, 1, 0, 0, 4'h0, 1, 1, 1, 1, 4'h0, 48'h1000, 48'h2000));
    for (int i = 2; i < 10; i++) tbl.push_back(row(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 4'h0, 0, 0));
    tbl.push_back(row(4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 1, 1, 4'h0, 0, 0));
    tbl.push_back(row(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h1, 0, 0));
    tbl.push_back(row(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(row(4'h2, 0, 0, 0, 0, 4'h2, 0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(row(4'h0, 0, 1, 0, 0, 4'h0, 1, 1, 1, 1, 4'h0, 48'h3000, 48'h4000));
    for (int i = 0; i < 3; i++) tbl.push_back(row(4'h1, 0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 4'h0, 48'h3000, 0));
    tbl.push_back(row(4'h1, 1, 0, 0, 0, 4'h0, 1, 0, 1, 1, 4'h0, 48'h3000, 0));
    tbl.push_back(row(4'h1, 0, 0, 0, 0, 4'h1, 0, 0, 1, 1, 4'h0, 0, 0));
    tbl.push_back(row(4'h0, 1, 1, 0, 0, 4'h0, 1, 1, 2, 1, 4'h0, 48'h1000, 48'h2000));
    tbl.push_back(row(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 2, 1, 4'h0, 0, 0));
    tbl.push_back(row(4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 2, 1, 4'h0, 0, 0));
    tbl.push_back(row(4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 1, 1, 4'h2, 0, 0));
    tbl.push_back(row(4'h0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 4'h1, 0, 0));
    tbl.push_back(row(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0));

    do_reset();
    chk("reset ready", snk0.ready, 0); chk("reset host valid", host0.valid, 0);
    chk("reset card valid", card0.valid, 0); chk("reset outstanding", out0, 0);
    chk("reset busy", busy0, 0); chk("reset err", err0, 0); chk("reset done", snk0.done, 0);

    snk0.req[0] = mk_req(48'h1000, 48'h2000, 28'd64);
    snk0.req[1] = mk_req(48'h3000, 48'h4000, 28'd128);
    foreach (tbl[i]) begin
      snk0.valid = tbl[i].v; host0.ready = tbl[i].hr; card0.ready = tbl[i].cr;
      card0.done = tbl[i].cd; host0.done = tbl[i].hd;
      #1;
      chk($sformatf("t%0d ready", i), snk0.ready, tbl[i].rdy);
      chk($sformatf("t%0d host valid", i), host0.valid, tbl[i].hv);
      chk($sformatf("t%0d card valid", i), card0.valid, tbl[i].cv);
      chk($sformatf("t%0d outstanding", i), out0, tbl[i].out);
      chk($sformatf("t%0d busy", i), busy0, tbl[i].bsy);
      chk($sformatf("t%0d done", i), snk0.done, tbl[i].dn);
      if (tbl[i].hv) chk($sformatf("t%0d host paddr", i), host0.req.paddr, tbl[i].hp);
      if (tbl[i].cv) chk($sformatf("t%0d card paddr", i), card0.req.paddr, tbl[i].cp);
      tick();
    end
    chk("table err", err0, 0);

    // Round robin over requesters 0,1,3 with both legs always ready
    do_reset();
    snk0.valid = 4'b1011; host0.ready = 1'b1; card0.ready = 1'b1;
    grants.delete(); last_cap = -1;
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      #1;
      if (snk0.ready != 0) begin
        chk("rr onehot", $onehot(snk0.ready), 1);
        if (last_cap >= 0) chk("rr spacing", c - last_cap, 2);
        last_cap = c;
        grants.push_back(bit_id(snk0.ready));
      end
      tick();
    end
    chk("rr grant count", grants.size(), 6);
    for (int k = 0; k < grants.size(); k++) chk($sformatf("rr grant %0d", k), grants[k], (k % 3 == 2) ? 3 : k % 3);

    // Credit limit: 8 captures then stall until one completion
    do_reset();
    snk0.valid = 4'hF; host0.ready = 1'b1; card0.ready = 1'b1; caps = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (snk0.ready != 0) caps++;
      tick();
    end
    chk("credit captures", caps, 8); chk("credit outstanding", out0, 8);
    #1 chk("credit ready held", snk0.ready, 0);
    card0.done = 1'b1;
    tick();
    card0.done = 1'b0;
    #1;
    chk("credit done to first id", snk0.done, 4'h1);
    chk("credit 9th ready", snk0.ready, 4'h1);
    chk("credit outstanding after pop", out0, 7);
    tick();
    chk("credit outstanding refill", out0, 8);

    // Mid-flight reset with three outstanding, third stuck in issue
    do_reset();
    for (int i = 0; i < 3; i++) begin
      snk0.valid = 4'h1; host0.ready = (i < 2); card0.ready = (i < 2);
      tick();
      snk0.valid = 4'h0;
      tick();
    end
    chk("mid pre host valid", host0.valid, 1); chk("mid pre outstanding", out0, 3);
    #2 aresetn = 1'b0;
    #1;
    chk("mid host valid", host0.valid, 0); chk("mid card valid", card0.valid, 0);
    chk("mid outstanding", out0, 0); chk("mid busy", busy0, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();
    chk("post outstanding", out0, 0); chk("post busy", busy0, 0); chk("post err", err0, 0);
    card0.done = 1'b1;
    tick();
    card0.done = 1'b0;
    chk("late done pulse", snk0.done, 0); chk("late done err", err0, 1);

    // RDWR=1 instance: host leg completes, card done ignored
    do_reset();
    host1.ready = 1'b1; card1.ready = 1'b1;
    snk1.req[0] = mk_req(48'h5000, 48'h6000, 28'd32);
    snk1.valid = 4'h1;
    #1 chk("r1 ready0", snk1.ready, 4'h1);
    tick();
    snk1.valid = 4'h0;
    chk("r1 host valid", host1.valid, 1); chk("r1 host paddr", host1.req.paddr, 48'h5000);
    tick();
    chk("r1 outstanding", out1, 1);
    card1.done = 1'b1;
    tick();
    card1.done = 1'b0;
    chk("r1 card done ignored", snk1.done, 0); chk("r1 card done count", out1, 1);
    snk1.valid = 4'h2; host1.done = 1'b1;
    #1 chk("r1 capture with done", snk1.ready, 4'h2);
    tick();
    snk1.valid = 4'h0; host1.done = 1'b0;
    chk("r1 count unchanged", out1, 1); chk("r1 done routed", snk1.done, 4'h1);
    tick();
    host1.done = 1'b1;
    tick();
    host1.done = 1'b0;
    chk("r1 second done", snk1.done, 4'h2); chk("r1 drained", out1, 0);
    host1.done = 1'b1;
    tick();
    host1.done = 1'b0;
    chk("r1 underflow pulse", snk1.done, 0); chk("r1 underflow err", err1, 1);
    chk("r1 isr_return", snk1.isr_return, 0);

    // Randomized traffic vs reference model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      v = 4'($urandom_range(0, 15));
      snk0.valid = v;
      for (int p = 0; p < N; p++) snk0.req[p] = rnd_req();
      host0.ready = ($urandom_range(0, 2) != 0);
      card0.ready = ($urandom_range(0, 2) != 0);
      card0.done = (m_q.size() > 0) && ($urandom_range(0, (c < 400) ? 5 : 1) == 0);
      host0.done = ($urandom_range(0, 3) == 0);
      #1;
      cap = !m_issue && v != 0 && m_q.size() < MAX;
      g = rr_pick(v, m_rr);
      exp_rdy = cap ? 4'(1 << g) : 4'h0;
      chk($sformatf("r%0d ready", c), snk0.ready, exp_rdy);
      chk($sformatf("r%0d host valid", c), host0.valid, m_hp);
      chk($sformatf("r%0d card valid", c), card0.valid, m_cp);
      chk($sformatf("r%0d outstanding", c), out0, m_q.size());
      chk($sformatf("r%0d busy", c), busy0, m_issue || m_q.size() > 0);
      chk($sformatf("r%0d done", c), snk0.done, m_done);
      chk($sformatf("r%0d err", c), err0, m_err);
      chk($sformatf("r%0d isr_return", c), snk0.isr_return, 0);
      if (m_hp) begin
        chk($sformatf("r%0d host paddr", c), host0.req.paddr, m_req.paddr_host);
        chk($sformatf("r%0d host len", c), host0.req.len, m_req.len);
      end
      if (m_cp) begin
        chk($sformatf("r%0d card paddr", c), card0.req.paddr, m_req.paddr_card);
        chk($sformatf("r%0d card dest", c), card0.req.dest, m_req.dest);
      end
      nd = '0;
      if (card0.done) begin
        if (m_q.size() > 0) nd = 4'(1 << m_q.pop_front());
        else m_err = 1;
      end
      if (cap) begin
        m_req = snk0.req[g]; m_q.push_back(g); m_rr = (g + 1) % N;
        m_issue = 1; m_hp = 1; m_cp = 1;
      end else if (m_issue) begin
        if (m_hp && host0.ready) m_hp = 0;
        if (m_cp && card0.ready) m_cp = 0;
        if (!m_hp && !m_cp) m_issue = 0;
      end
      m_done = nd;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
